shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (product width is 2*WIDTH).
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to multiply; sampled on the rising edge of clock.
REQ-005 a  input  WIDTH  multiplicand operand; unsigned; from the operand-load stage.
REQ-006 b  input  WIDTH  multiplier operand; unsigned.
REQ-007 busy  output  1  high while an operation is iterating.
REQ-008 done  output  1  one-cycle pulse marking a new valid product.
REQ-009 product  output  2*WIDTH  registered result; unsigned; drives the hex display decoders.

Function
REQ-010 The block SHALL implement states IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 at an edge SHALL capture a and b into internal registers, clear the iteration count, and enter RUN.
REQ-012 In RUN, start SHALL be ignored; a and b may change without effect on the operation in progress.
REQ-013 Each RUN cycle SHALL perform one iteration:
  - if the multiplier LSB is 1, add the multiplicand to the upper accumulator half, producing a (WIDTH+1)-bit sum with carry;
  - shift {carry, upper, multiplier} right by one;
  - increment the count.
REQ-014 After exactly WIDTH RUN edges, the block SHALL:
  - write the full 2*WIDTH accumulator into product;
  - enter DONE.
REQ-015 Latency: capture at edge k; product updated and done=1 after edge k+WIDTH, i.e. 8 cycles for WIDTH=8.
REQ-016 done SHALL be high only in DONE, which lasts one cycle.
REQ-017 DONE SHALL return to IDLE unless start=1, in which case it goes to RUN (back-to-back operation).
REQ-018 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-019 product SHALL hold its last value in IDLE and throughout RUN; it changes only on the edge entering DONE.
REQ-020 Arithmetic SHALL be exact unsigned; no truncation; maximum result is (2^WIDTH-1)^2.
REQ-021 Zero operands SHALL still take the full WIDTH iterations; there is no early termination.
REQ-022 The count SHALL be ceil(log2(WIDTH+1)) bits; states outside the legal encoding SHALL recover to IDLE on the next edge.

Reset
REQ-023 reset=0 SHALL immediately, regardless of clock, force:
  - state=IDLE;
  - count=0;
  - operand and accumulator registers=0;
  - product=0, busy=0, done=0.
REQ-024 reset asserted mid-RUN SHALL abort the operation; no done pulse follows.
REQ-025 After reset deasserts, the first start SHALL behave as in REQ-011.

Structure
REQ-026 A shared package SHALL hold:
  - the state enumeration (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - the count-width function.
REQ-027 The (WIDTH+1)-bit conditional adder SHALL be one sub-module, cond_adder, with inputs acc_hi, mcand and en, and output sum with carry.
REQ-028 The FSM, count, shift register and product register SHALL reside in shift_add_multiplier.

Verification
REQ-029 Reset, then start with a=0x0C, b=0x0A -> busy for 8 cycles, done pulse once, product=0x0078.
REQ-030 a=0xFF, b=0xFF -> product=0xFE01 after 8 cycles; a=0x00, b=0xFF -> product=0x0000, still 8 cycles.
REQ-031 start re-pulsed at RUN cycle 3 with a=0x01, b=0x01 -> ignored; original product delivered; exactly one done.
REQ-032 reset=0 asserted mid-RUN (cycle 4), with no clock edge -> product=0, busy=0 at once; no done after release.
REQ-033 start held high through DONE with new a=0x10, b=0x10 -> first product, then RUN immediately; second done 8 cycles later with product=0x0100.
REQ-034 Random 1000 operand pairs -> product equals a*b; done count equals accepted starts.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier; no logic, no latency.
// State encoding, default operand width and iteration-counter sizing.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier; combinational wiring only.
// No backpressure: start is simply ignored while the multiplier is busy.
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/shift_add_multiplier_cond_adder.sv
// Conditional adder: sum = acc_hi + (en ? mcand : 0) with carry-out; purely combinational.
// No backpressure; result valid in the same cycle as the inputs.
module cond_adder
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] mcand,
    input  logic             en,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] addend;

    assign addend = en ? mcand : '0;
    assign sum    = {1'b0, acc_hi} + {1'b0, addend};

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier; product valid WIDTH cycles after start is taken.
// No backpressure: start is ignored in RUN, honoured in IDLE and DONE (back-to-back).
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    shift_add_multiplier_if.slave  mul_if
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum;

    cond_adder #(
        .WIDTH (WIDTH)
    ) u_cond_adder (
        .acc_hi (acc_hi_q),
        .mcand  (mcand_q),
        .en     (mplier_q[0]),
        .sum    (sum)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        mplier_d  = mplier_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (mul_if.start) begin
                    mcand_d  = mul_if.a;
                    mplier_d = mul_if.b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // {carry, acc_hi, mplier} >> 1; the vacated multiplier bit is consumed
                acc_hi_d = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    product_d = {sum, mplier_q[WIDTH-1:1]};
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    assign mul_if.busy    = (state_q == ST_RUN);
    assign mul_if.done    = (state_q == ST_DONE);
    assign mul_if.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at WIDTH=8.
module tb_shift_add_multiplier;

    logic clock;
    logic reset;

    shift_add_multiplier_if #(.WIDTH(8)) mif ();

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .mul_if (mif.slave)
    );

    int n_checks;
    int n_fail;
    int done_cnt;
    int exp_done;
    logic [15:0] last_prod;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mif.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called one cycle into RUN; waits for done and checks latency, hold and result.
    task automatic wait_done(input string tag, input logic [15:0] exp, input int lat);
        int cycles;
        cycles = 0;
        while (mif.done !== 1'b1 && cycles < 20) begin
            check({tag, "_hold"}, mif.product, last_prod);
            check({tag, "_busy"}, mif.busy, 1);
            tick();
            cycles++;
        end
        check({tag, "_lat"}, cycles, lat);
        check({tag, "_prod"}, mif.product, exp);
        check({tag, "_busy_done"}, mif.busy, 0);
        last_prod = exp;
        exp_done++;
    endtask

    task automatic do_mul(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
        mif.start = 1'b1;
        mif.a     = av;
        mif.b     = bv;
        tick();
        mif.start = 1'b0;
        wait_done(tag, exp, 8);
        tick();
        check({tag, "_done_clr"}, mif.done, 0);
    endtask

    initial begin
        int d0;
        logic [7:0] ra, rb;
        n_checks  = 0;
        n_fail    = 0;
        done_cnt  = 0;
        exp_done  = 0;
        last_prod = 16'h0000;
        reset     = 1'b0;
        mif.start = 1'b0;
        mif.a     = 8'h00;
        mif.b     = 8'h00;

        tick();
        tick();
        check("rst_busy", mif.busy, 0);
        check("rst_done", mif.done, 0);
        check("rst_prod", mif.product, 0);
        reset = 1'b1;
        tick();

        do_mul("basic", 8'h0C, 8'h0A, 16'h0078);
        do_mul("max",   8'hFF, 8'hFF, 16'hFE01);
        do_mul("zero",  8'h00, 8'hFF, 16'h0000);
        do_mul("one",   8'h01, 8'h80, 16'h0080);

        // start re-pulse during RUN is ignored
        d0 = done_cnt;
        mif.start = 1'b1; mif.a = 8'h37; mif.b = 8'h05;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        mif.start = 1'b1; mif.a = 8'h01; mif.b = 8'h01;
        tick();
        mif.start = 1'b0;
        wait_done("ignore", 16'h0113, 5);
        tick();
        check("ignore_one_done", done_cnt - d0, 1);

        // asynchronous reset mid-RUN
        mif.start = 1'b1; mif.a = 8'h0C; mif.b = 8'h0A;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("abort_prod", mif.product, 0);
        check("abort_busy", mif.busy, 0);
        check("abort_done", mif.done, 0);
        last_prod = 16'h0000;
        tick();
        tick();
        reset = 1'b1;
        d0 = done_cnt;
        repeat (12) tick();
        check("abort_no_done", done_cnt - d0, 0);
        do_mul("post_rst", 8'h0C, 8'h0A, 16'h0078);

        // start held through DONE: back-to-back operations
        mif.start = 1'b1; mif.a = 8'h03; mif.b = 8'h05;
        tick();
        mif.a = 8'h10; mif.b = 8'h10;
        wait_done("b2b1", 16'h000F, 8);
        tick();
        check("b2b_rerun_busy", mif.busy, 1);
        check("b2b_rerun_done", mif.done, 0);
        mif.start = 1'b0;
        wait_done("b2b2", 16'h0100, 8);
        tick();
        check("b2b_done_clr", mif.done, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_mul("rand", ra, rb, 16'(ra) * 16'(rb));
        end

        check("done_count", done_cnt, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
